uart_echo_fifo: RTL and testbench

Buffering and sequencing stage between the UART receiver and the UART transmitter in the echo path. It captures each byte the receiver flags valid into a circular FIFO. It then drains the FIFO into the transmitter using a start/ready handshake, so bytes that arrive back-to-back while the transmitter is busy are not lost. It replaces the direct receiver-to-transmitter register and free-running start logic in the top level.

---
 rtl/uart_echo_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_echo_fifo.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_echo_fifo
// Brief   : Captures UART receive bytes into a circular FIFO and drains them
//           into the UART transmitter with a start/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module uart_echo_fifo #(
   parameter int DATA_W       = 8,
   parameter int DEPTH_LOG2   = 4,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     rx_data,
   input  logic                  rx_valid,
   input  logic                  tx_ready,
   output logic                  tx_start,
   output logic [DATA_W-1:0]     tx_data,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   input  logic                  clear_ovf
);

   localparam int                  C_DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] C_FULL_COUNT = (DEPTH_LOG2 + 1)'(C_DEPTH);
   localparam int                  C_TMR_W      = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [C_TMR_W-1:0]  C_TMR_LAST   = C_TMR_W'(BUSY_TIMEOUT - 1);

   localparam logic [1:0] C_IDLE      = 2'd0;
   localparam logic [1:0] C_START     = 2'd1;
   localparam logic [1:0] C_WAIT_BUSY = 2'd2;
   localparam logic [1:0] C_WAIT_IDLE = 2'd3;

   logic [DATA_W-1:0]     r_mem [C_DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_empty;
   logic                  r_full;
   logic                  r_overflow;
   logic [DATA_W-1:0]     r_tx_data;
   logic                  r_rx_valid_d;
   logic [1:0]            r_state;
   logic [1:0]            w_state_next;
   logic [C_TMR_W-1:0]    r_timer;

   logic                  w_wr_req;
   logic                  w_wr;
   logic                  w_drop;
   logic                  w_pop;
   logic                  w_tmr_clr;
   logic                  w_tmr_inc;
   logic [DEPTH_LOG2:0]   w_count_next;

   // A held rx_valid level produces a single write on its rising edge.
   assign w_wr_req = rx_valid & ~r_rx_valid_d;
   // When full, a pop in the same cycle frees the slot the write will use.
   assign w_wr     = w_wr_req & (~r_full | w_pop);
   assign w_drop   = w_wr_req & r_full & ~w_pop;

   always_comb begin
      w_count_next = r_count;
      case ({w_wr, w_pop})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - 1'b1;
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_valid_d <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_empty      <= 1'b1;
         r_full       <= 1'b0;
         r_overflow   <= 1'b0;
         r_tx_data    <= '0;
      end else begin
         r_rx_valid_d <= rx_valid;
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_tx_data <= r_mem[r_rd_ptr];
         end
         r_count <= w_count_next;
         r_empty <= (w_count_next == '0);
         r_full  <= (w_count_next == C_FULL_COUNT);
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clear_ovf) begin
            r_overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= C_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         C_IDLE:      if (!r_empty && tx_ready) w_state_next = C_START;
         C_START:     w_state_next = C_WAIT_BUSY;
         C_WAIT_BUSY: begin
            if (!tx_ready) begin
               w_state_next = C_WAIT_IDLE;
            end else if (r_timer == C_TMR_LAST) begin
               w_state_next = C_START;
            end
         end
         C_WAIT_IDLE: if (tx_ready) w_state_next = C_IDLE;
         default:     w_state_next = C_IDLE;
      endcase
   end

   always_comb begin
      w_pop     = 1'b0;
      tx_start  = 1'b0;
      w_tmr_clr = 1'b0;
      w_tmr_inc = 1'b0;
      case (r_state)
         C_IDLE:      w_pop = !r_empty && tx_ready;
         C_START: begin
            tx_start  = 1'b1;
            w_tmr_clr = 1'b1;
         end
         C_WAIT_BUSY: w_tmr_inc = tx_ready;
         default:     ;
      endcase
   end

   // Counts cycles the transmitter ignores a start; expiry re-issues it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_timer <= '0;
      end else if (w_tmr_clr) begin
         r_timer <= '0;
      end else if (w_tmr_inc) begin
         r_timer <= r_timer + 1'b1;
      end
   end

   assign tx_data  = r_tx_data;
   assign count    = r_count;
   assign empty    = r_empty;
   assign full     = r_full;
   assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_echo_fifo
// Brief   : Self-checking bench for uart_echo_fifo (vector table + sequences).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_echo_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_ready;
   logic       clear_ovf;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [4:0] count;
   logic       empty;
   logic       full;
   logic       overflow;

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] got [$];

   typedef struct {
      logic       rv;
      logic [7:0] d;
      logic       rdy;
      logic       clr;
      logic       e_start;
      logic [7:0] e_data;
      logic [4:0] e_count;
      logic       e_empty;
      logic       e_full;
      logic       e_ovf;
   } vec_t;

   vec_t vecs [$];

   always #5 clk = ~clk;

   uart_echo_fifo #(
      .DATA_W       (8),
      .DEPTH_LOG2   (4),
      .BUSY_TIMEOUT (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_ready  (tx_ready),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .clear_ovf (clear_ovf)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic rv, input logic [7:0] d, input logic rdy, input logic clr,
                      input logic es, input logic [7:0] ed, input logic [4:0] ec,
                      input logic ee, input logic ef, input logic eo);
      vec_t v;
      v.rv = rv; v.d = d; v.rdy = rdy; v.clr = clr;
      v.e_start = es; v.e_data = ed; v.e_count = ec;
      v.e_empty = ee; v.e_full = ef; v.e_ovf = eo;
      vecs.push_back(v);
   endtask

   task automatic write_byte(input logic [7:0] d);
      rx_data  = d;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      step();
   endtask

   // Transmitter model: drops ready for 20 cycles after each start.
   task automatic drain(input int n);
      int   busy_cnt = 0;
      int   cyc      = 0;
      logic prev     = 1'b0;
      got.delete();
      tx_ready = 1'b1;
      while ((got.size() < n || busy_cnt > 0) && cyc < 3000) begin
         step();
         cyc++;
         if (tx_start) begin
            chk("start_gap", {31'd0, prev}, 32'd0);
            got.push_back(tx_data);
            tx_ready = 1'b0;
            busy_cnt = 20;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_ready = 1'b1;
         end
         prev = tx_start;
      end
      chk("drain_budget", {31'd0, (cyc < 3000)}, 32'd1);
      step();
      step();
   endtask

   initial begin
      int         gap;
      logic       found;
      int         starts;
      logic [7:0] exp_b;

      reset     = 1'b1;
      rx_data   = 8'h00;
      rx_valid  = 1'b0;
      tx_ready  = 1'b1;
      clear_ovf = 1'b0;
      step();
      step();
      chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
      chk("rst_count", {27'd0, count}, 32'd0);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      reset = 1'b0;

      // single byte, then held valid level
      add(1'b1, 8'h41, 1'b1, 1'b0,  1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 8'h41, 1'b1, 1'b0,  1'b1, 8'h41, 5'd0, 1'b1, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h41, 5'd0, 1'b1, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b0, 1'b1,  1'b0, 8'h41, 5'd0, 1'b1, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 8'h41, 5'd0, 1'b1, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 8'h41, 5'd0, 1'b1, 1'b0, 1'b0);
      add(1'b1, 8'h5A, 1'b1, 1'b0,  1'b0, 8'h41, 5'd1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 8'h5A, 1'b1, 1'b0,  1'b1, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         add(1'b1, 8'h5A, 1'b0, 1'b0,  1'b0, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0);
      end
      add(1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         rx_valid  = vecs[i].rv;
         rx_data   = vecs[i].d;
         tx_ready  = vecs[i].rdy;
         clear_ovf = vecs[i].clr;
         step();
         chk($sformatf("vec%0d_tx_start", i), {31'd0, tx_start}, {31'd0, vecs[i].e_start});
         chk($sformatf("vec%0d_tx_data", i), {24'd0, tx_data}, {24'd0, vecs[i].e_data});
         chk($sformatf("vec%0d_count", i), {27'd0, count}, {27'd0, vecs[i].e_count});
         chk($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].e_empty});
         chk($sformatf("vec%0d_full", i), {31'd0, full}, {31'd0, vecs[i].e_full});
         chk($sformatf("vec%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].e_ovf});
      end
      rx_valid  = 1'b0;
      clear_ovf = 1'b0;

      // burst while the transmitter is busy
      tx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) write_byte(8'(i));
      chk("burst_count", {27'd0, count}, 32'd5);
      drain(5);
      chk("burst_n", got.size(), 32'd5);
      for (int i = 0; i < got.size(); i++) begin
         chk($sformatf("burst_byte%0d", i), {24'd0, got[i]}, i + 1);
      end
      chk("burst_empty", {31'd0, empty}, 32'd1);

      // overflow, clear, set-wins and full-with-pop
      tx_ready = 1'b0;
      for (int i = 0; i < 16; i++) write_byte(8'(i));
      chk("ovf_count16", {27'd0, count}, 32'd16);
      chk("ovf_full", {31'd0, full}, 32'd1);
      chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
      write_byte(8'h10);
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      chk("ovf_count_held", {27'd0, count}, 32'd16);
      clear_ovf = 1'b1;
      step();
      clear_ovf = 1'b0;
      chk("ovf_cleared", {31'd0, overflow}, 32'd0);
      rx_data   = 8'h55;
      rx_valid  = 1'b1;
      clear_ovf = 1'b1;
      step();
      chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
      rx_valid  = 1'b0;
      clear_ovf = 1'b0;
      step();
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);
      clear_ovf = 1'b1;
      step();
      clear_ovf = 1'b0;
      chk("ovf_cleared2", {31'd0, overflow}, 32'd0);
      rx_data  = 8'h77;
      rx_valid = 1'b1;
      tx_ready = 1'b1;
      step();
      chk("fullpop_count", {27'd0, count}, 32'd16);
      chk("fullpop_full", {31'd0, full}, 32'd1);
      chk("fullpop_ovf", {31'd0, overflow}, 32'd0);
      chk("fullpop_start", {31'd0, tx_start}, 32'd1);
      chk("fullpop_data", {24'd0, tx_data}, 32'h00);
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      step();
      step();
      drain(16);
      chk("wrap_n", got.size(), 32'd16);
      for (int i = 0; i < got.size(); i++) begin
         exp_b = (i < 15) ? 8'(i + 1) : 8'h77;
         chk($sformatf("wrap_byte%0d", i), {24'd0, got[i]}, {24'd0, exp_b});
      end
      chk("wrap_empty", {31'd0, empty}, 32'd1);

      // timeout retry: transmitter never acknowledges the first start
      tx_ready = 1'b0;
      write_byte(8'h3C);
      write_byte(8'h3D);
      chk("retry_count2", {27'd0, count}, 32'd2);
      tx_ready = 1'b1;
      step();
      chk("retry_first_start", {31'd0, tx_start}, 32'd1);
      chk("retry_first_data", {24'd0, tx_data}, 32'h3C);
      chk("retry_first_count", {27'd0, count}, 32'd1);
      gap   = 0;
      found = 1'b0;
      for (int i = 1; i <= 40 && !found; i++) begin
         step();
         if (tx_start) begin
            found = 1'b1;
            gap   = i;
         end
      end
      chk("retry_gap", gap, 32'd17);
      chk("retry_data", {24'd0, tx_data}, 32'h3C);
      chk("retry_count", {27'd0, count}, 32'd1);
      tx_ready = 1'b0;
      step();
      step();
      drain(1);
      chk("retry_next_n", got.size(), 32'd1);
      if (got.size() > 0) chk("retry_next_byte", {24'd0, got[0]}, 32'h3D);

      // asynchronous reset while waiting for the transmitter to finish
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) write_byte(8'hA1 + 8'(i));
      tx_ready = 1'b1;
      step();
      chk("mid_start", {31'd0, tx_start}, 32'd1);
      chk("mid_count3", {27'd0, count}, 32'd3);
      tx_ready = 1'b0;
      step();
      step();
      #2 reset = 1'b1;
      #1;
      chk("arst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("arst_count", {27'd0, count}, 32'd0);
      chk("arst_empty", {31'd0, empty}, 32'd1);
      chk("arst_overflow", {31'd0, overflow}, 32'd0);
      chk("arst_tx_data", {24'd0, tx_data}, 32'h00);
      step();
      reset    = 1'b0;
      tx_ready = 1'b1;
      starts   = 0;
      repeat (10) begin
         step();
         if (tx_start) starts++;
      end
      chk("arst_no_start", starts, 32'd0);
      write_byte(8'hB7);
      chk("arst_new_start", {31'd0, tx_start}, 32'd1);
      chk("arst_new_data", {24'd0, tx_data}, 32'hB7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
